// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the small decode helpers used when a request is accepted.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // Byte enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   byte_mask = 4'b0001 << addr_lo;
            2'b01:   byte_mask = 4'b0011 << addr_lo;
            default: byte_mask = 4'b1111;
        endcase
    endfunction

    // Replicate right-aligned store data across every lane it could land in,
    // so the byte mask alone selects the target bytes.
    function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] wdata);
        case (funct3[1:0])
            2'b00:   store_lanes = {4{wdata[7:0]}};
            2'b01:   store_lanes = {2{wdata[15:0]}};
            default: store_lanes = wdata;
        endcase
    endfunction

    // Size/alignment/funct3 legality; unsigned variants exist only for loads.
    function automatic logic is_legal(input logic store, input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_B:    is_legal = 1'b1;
            F3_H:    is_legal = ~addr_lo[0];
            F3_W:    is_legal = (addr_lo == 2'b00);
            F3_BU:   is_legal = ~store;
            F3_HU:   is_legal = ~store & ~addr_lo[0];
            default: is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational byte/halfword lane select with sign or zero extension of a
// returned RAM word. Kept standalone so a cache return path can share it.
module load_extract
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addrLo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  lanes [4];
    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Split the word into its four byte lanes.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lanes[gi] = word[8*gi +: 8];
    end

    // Pick the addressed lane(s) and extend according to the load type.
    always_comb begin
        byteSel = lanes[addrLo];
        halfSel = addrLo[1] ? {lanes[3], lanes[2]} : {lanes[1], lanes[0]};
        case (funct3)
            F3_B:    result = {{24{byteSel[7]}}, byteSel};
            F3_H:    result = {{16{halfSel[15]}}, halfSel};
            F3_BU:   result = {24'd0, byteSel};
            F3_HU:   result = {16'd0, halfSel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage initiator for the data RAM. One request per handshake; the
// RAM-side controls are registered at accept time so they appear in the cycle
// after the handshake with no combinational path from the request inputs.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqStore,
    input  logic [2:0]  reqFunct3,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWData,
    output logic        loadValid,
    output logic [31:0] loadData,
    output logic        storeDone,
    output logic        accessErr,
    output logic [31:0] memAddr,
    output logic        memRstrb,
    output logic [31:0] memWData,
    output logic [3:0]  memWMask,
    input  logic [31:0] memRData
);

    // Counter preload: the final WAIT cycle lines up with READ_LATENCY
    // cycles after the strobe cycle.
    localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

    lsu_state_t  state;
    logic        latStore;
    logic        latLegal;
    logic [2:0]  latFunct3;
    logic [1:0]  latAddrLo;
    logic [1:0]  latCnt;
    logic        reqLegal;
    logic [31:0] extracted;

    // Legality of the request currently on the input port.
    always_comb begin
        reqLegal = is_legal(reqStore, reqFunct3, reqAddr[1:0]);
    end

    load_extract u_extract (
        .word   (memRData),
        .addrLo (latAddrLo),
        .funct3 (latFunct3),
        .result (extracted)
    );

    // Request FSM with registered RAM-side and result outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            reqReady  <= 1'b1;
            latStore  <= 1'b0;
            latLegal  <= 1'b0;
            latFunct3 <= 3'd0;
            latAddrLo <= 2'd0;
            latCnt    <= 2'd0;
            loadValid <= 1'b0;
            loadData  <= 32'd0;
            storeDone <= 1'b0;
            accessErr <= 1'b0;
            memAddr   <= 32'd0;
            memRstrb  <= 1'b0;
            memWData  <= 32'd0;
            memWMask  <= 4'd0;
        end else begin
            // Pulse outputs default low every cycle.
            memRstrb  <= 1'b0;
            memWMask  <= 4'd0;
            storeDone <= 1'b0;
            accessErr <= 1'b0;
            loadValid <= 1'b0;

            case (state)
                IDLE: begin
                    if (reqValid) begin
                        latStore  <= reqStore;
                        latLegal  <= reqLegal;
                        latFunct3 <= reqFunct3;
                        latAddrLo <= reqAddr[1:0];
                        memAddr   <= {reqAddr[31:2], 2'b00};
                        if (!reqLegal) begin
                            accessErr <= 1'b1;
                        end else if (reqStore) begin
                            memWMask  <= byte_mask(reqFunct3, reqAddr[1:0]);
                            memWData  <= store_lanes(reqFunct3, reqWData);
                            storeDone <= 1'b1;
                        end else begin
                            memRstrb  <= 1'b1;
                        end
                        reqReady <= 1'b0;
                        state    <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (latLegal && !latStore) begin
                        latCnt <= LAT_INIT;
                        state  <= WAIT;
                    end else begin
                        reqReady <= 1'b1;
                        state    <= IDLE;
                    end
                end

                WAIT: begin
                    if (latCnt == 2'd0) begin
                        loadData  <= extracted;
                        loadValid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        latCnt <= latCnt - 2'd1;
                    end
                end

                RESP: begin
                    reqReady <= 1'b1;
                    state    <= IDLE;
                end

                default: begin
                    reqReady <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
